spike_decoder: RTL

SPIKE_DECODER -- requirements
Module: spike_decoder

---
 rtl/snn_pkg.sv | 13 +
 rtl/spike_counter.sv | 36 +++
 rtl/spike_decoder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and default widths for the spiking-network readout blocks.
package snn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 8;
    localparam int WIN_W_DEF  = 8;

endpackage

// File: rtl/spike_counter.sv
// One saturating spike counter; exposes its next value so a window's final
// count (including the last cycle's spike) can be captured on the same edge.
module spike_counter
    import snn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             start_i,
    input  logic             spike_i,
    output logic [CNT_W-1:0] cnt_nxt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A window start discards the old count and counts the start cycle's spike.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (start_i)
            cnt_d = {{(CNT_W-1){1'b0}}, spike_i};
        else if (spike_i && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/spike_decoder.sv
// Windowed spike-count decoder with held result and sticky overrun flag.
// Define SPIKE_DECODER_WTA_EN to add the winner-take-all index and tie flag.
module spike_decoder
    import snn_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WIN_W  = WIN_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       spike_in,
    input  logic [WIN_W-1:0]        win_len,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*CNT_W-1:0] out_counts,
    output logic [2:0]              out_winner,
    output logic                    out_tie,
    output logic                    overrun
);

    state_e                         state_q, state_d;
    logic [WIN_W-1:0]               win_q, win_d, rem;
    logic                           start, last, clr;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_nxt;
    logic [NUM_CH-1:0][CNT_W-1:0]   counts_q, counts_d;
    logic [2:0]                     win_idx, winner_q, winner_d;
    logic                           tie, tie_q, tie_d;
    logic                           valid_q, valid_d, ovr_q, ovr_d, load;

    // win_q holds the cycles left in the window including the current one;
    // zero while COUNT means the previous window just ended and a new one
    // starts now.
    always_comb begin
        state_d = state_q;
        win_d   = '0;
        start   = 1'b0;
        last    = 1'b0;
        clr     = !enable;
        rem     = win_q;
        case (state_q)
            IDLE:    if (enable) begin
                         state_d = COUNT;
                         start   = 1'b1;
                     end
            COUNT:   if (!enable) state_d = IDLE;
                     else if (win_q == '0) start = 1'b1;
            default: state_d = IDLE;
        endcase
        if (start) rem = (win_len == '0) ? WIN_W'(1) : win_len;
        if (enable) begin
            last  = (rem == WIN_W'(1));
            win_d = last ? '0 : rem - 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        spike_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr_i     (clr),
            .start_i   (start),
            .spike_i   (spike_in[g]),
            .cnt_nxt_o (cnt_nxt[g])
        );
    end

`ifdef SPIKE_DECODER_WTA_EN
    logic [CNT_W-1:0] best;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best    = cnt_nxt[0];
        win_idx = '0;
        tie     = 1'b0;
        for (int i = 1; i < NUM_CH; i++) begin
            if (cnt_nxt[i] > best) begin
                best    = cnt_nxt[i];
                win_idx = 3'(i);
                tie     = 1'b0;
            end else if (cnt_nxt[i] == best) begin
                tie = 1'b1;
            end
        end
    end
`else
    assign win_idx = '0;
    assign tie     = 1'b0;
`endif

    // A finished window is dropped only when an unconsumed result is held.
    always_comb begin
        load     = last && (!valid_q || out_ready);
        ovr_d    = ovr_q | (last && valid_q && !out_ready);
        valid_d  = load ? 1'b1 : (valid_q && !out_ready);
        counts_d = load ? cnt_nxt : counts_q;
        winner_d = load ? win_idx : winner_q;
        tie_d    = load ? tie     : tie_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            win_q    <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            counts_q <= '0;
            winner_q <= '0;
            tie_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            counts_q <= counts_d;
            winner_q <= winner_d;
            tie_q    <= tie_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_counts = counts_q;
    assign out_winner = winner_q;
    assign out_tie    = tie_q;
    assign overrun    = ovr_q;

endmodule
